// File: rtl/fft_out_reorder.sv
// Natural-order reorder buffer behind an FFT core.
// Collects one frame into RAM, then drains it in index order.
module fft_out_reorder #(
  parameter int WIDTH = 18,
  parameter int AW    = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] di_re,
  input  logic [WIDTH-1:0] di_im,
  input  logic             di_en,
  input  logic [AW-1:0]    di_address,
  input  logic             finish,
  input  logic [AW-1:0]    points,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] do_re,
  output logic [WIDTH-1:0] do_im,
  output logic             do_valid,
  output logic             do_last,
  output logic             busy,
  output logic             overflow,
  output logic             seq_err
);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

  localparam int SW = 2 * WIDTH;
  localparam int EW = SW + 1;

  state_t          state;
  logic [AW-1:0]   points_q;
  logic [AW-1:0]   wr_cnt;
  logic [AW-1:0]   rd_ptr;
  logic [SW-1:0]   mem [0:(1<<AW)-1];
  logic [SW-1:0]   rd_data;
  logic            rd_vld;
  logic            rd_last;
  logic [EW-1:0]   sk0, sk1, sk0_n, sk1_n;
  logic [1:0]      skid_cnt, cnt_n;
  logic [EW-1:0]   rd_word, out_n;
  logic            out_free, out_ld;
  logic            wr_en, rd_issue, final_wr, xfer_last;

  assign wr_en = di_en && ((state == IDLE && points != '0) || state == COLLECT);
  assign final_wr = (state == IDLE) ? (points == AW'(1))
                                    : (wr_cnt == points_q - AW'(1));
  assign rd_issue = (state == DRAIN) && (rd_ptr != points_q) &&
                    ((skid_cnt == 2'd0) || (skid_cnt == 2'd1 && !rd_vld));
  assign rd_word = {rd_data, rd_last};
  assign xfer_last = do_valid && rd_ready && do_last;

  // Frame buffer: write port from the FFT, registered read port for drain
  always_ff @(posedge clk) begin
    if (wr_en) mem[di_address] <= {di_re, di_im};
    if (rd_issue) rd_data <= mem[rd_ptr];
  end

  // Frame sequencing and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      points_q <= '0;
      wr_cnt   <= '0;
      rd_ptr   <= '0;
      busy     <= 1'b0;
      overflow <= 1'b0;
      seq_err  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          rd_ptr <= '0;
          if (di_en && points != '0) begin
            points_q <= points;
            wr_cnt   <= AW'(1);
            busy     <= 1'b1;
            state    <= final_wr ? DRAIN : COLLECT;
            if (finish != final_wr) seq_err <= 1'b1;
          end
        end
        COLLECT: begin
          if (di_en) begin
            wr_cnt <= wr_cnt + AW'(1);
            if (finish != final_wr) seq_err <= 1'b1;
            if (final_wr) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (di_en) overflow <= 1'b1;
          if (rd_issue) rd_ptr <= rd_ptr + AW'(1);
          if (xfer_last) begin
            state  <= IDLE;
            busy   <= 1'b0;
            wr_cnt <= '0;
            rd_ptr <= '0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Route RAM data to the output register or the 2-entry skid
  always_comb begin
    out_free = !do_valid || rd_ready;
    sk0_n    = sk0;
    sk1_n    = sk1;
    cnt_n    = skid_cnt;
    out_ld   = 1'b0;
    out_n    = rd_word;
    if (out_free) begin
      if (skid_cnt != 2'd0) begin
        out_ld = 1'b1;
        out_n  = sk0;
        sk0_n  = sk1;
        cnt_n  = skid_cnt - 2'd1 + {1'b0, rd_vld};
        if (rd_vld) begin
          if (skid_cnt == 2'd1) sk0_n = rd_word;
          else sk1_n = rd_word;
        end
      end else if (rd_vld) begin
        out_ld = 1'b1;
      end
    end else if (rd_vld) begin
      if (skid_cnt == 2'd0) sk0_n = rd_word;
      else sk1_n = rd_word;
      cnt_n = skid_cnt + 2'd1;
    end
  end

  // Read pipeline, skid storage and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld   <= 1'b0;
      rd_last  <= 1'b0;
      sk0      <= '0;
      sk1      <= '0;
      skid_cnt <= 2'd0;
      do_valid <= 1'b0;
      do_last  <= 1'b0;
      do_re    <= '0;
      do_im    <= '0;
    end else begin
      rd_vld   <= rd_issue;
      rd_last  <= rd_issue && (rd_ptr == points_q - AW'(1));
      sk0      <= sk0_n;
      sk1      <= sk1_n;
      skid_cnt <= cnt_n;
      if (out_free) begin
        do_valid <= out_ld;
        do_last  <= out_ld && out_n[0];
        if (out_ld) begin
          do_re <= out_n[EW-1:WIDTH+1];
          do_im <= out_n[WIDTH:1];
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_out_reorder.sv
// Randomized bench for fft_out_reorder.
// Frames are modelled as an index-addressed array.
module tb_fft_out_reorder;

  localparam int W  = 18;
  localparam int AW = 11;
  localparam int DW = 2 * W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  di_re = '0, di_im = '0;
  logic          di_en = 1'b0;
  logic [AW-1:0] di_address = '0;
  logic          finish = 1'b0;
  logic [AW-1:0] points = '0;
  logic          rd_ready = 1'b1;
  logic [W-1:0]  do_re, do_im;
  logic          do_valid, do_last, busy, overflow, seq_err;

  logic [DW-1:0] model [0:(1<<AW)-1];
  int n_cmp = 0;
  int n_bad = 0;
  int fv, cy;

  fft_out_reorder #(.WIDTH(W), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .di_re(di_re), .di_im(di_im), .di_en(di_en),
    .di_address(di_address), .finish(finish), .points(points),
    .rd_ready(rd_ready),
    .do_re(do_re), .do_im(do_im), .do_valid(do_valid),
    .do_last(do_last), .busy(busy), .overflow(overflow),
    .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask

  // One frame in a scrambled (stride-7 rotated) address order
  task automatic collect(input int n, input int fin_pos);
    int r, a;
    logic [DW-1:0] d;
    r = $urandom_range(0, n - 1);
    points = AW'(n);
    for (int i = 0; i < n; i++) begin
      a = (i * 7 + r) % n;
      d = DW'({$urandom(), $urandom()});
      di_en = 1'b1;
      di_address = AW'(a);
      di_re = d[DW-1:W];
      di_im = d[W-1:0];
      finish = (i == fin_pos);
      model[a] = d;
      tick;
    end
    di_en = 1'b0;
    finish = 1'b0;
  endtask

  // Consume words, checking order, last flag and stall stability
  task automatic drain(input int n, input bit rnd, input int inject,
                       input int stop_at, output int first_v,
                       output int cycles);
    int got, cyc;
    bit stall, rdy;
    logic [DW+1:0] held, cur;
    got = 0;
    cyc = 0;
    stall = 1'b0;
    held = '0;
    first_v = -1;
    while (got < stop_at && cyc < 20 * n + 50) begin
      cur = {do_valid, do_last, do_re, do_im};
      if (stall) chk("stall_hold", 64'(cur), 64'(held));
      if (do_valid && first_v < 0) first_v = cyc;
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      rd_ready = rdy;
      di_en = (cyc == inject);
      if (cyc == inject) begin
        di_address = '0;
        di_re = ~model[0][DW-1:W];
        di_im = ~model[0][W-1:0];
      end
      if (do_valid && rdy) begin
        chk("word", 64'({do_re, do_im}), 64'(model[got]));
        chk("last", 64'(do_last), 64'(got == n - 1));
        got++;
      end
      stall = do_valid && !rdy;
      held = cur;
      tick;
      cyc++;
    end
    di_en = 1'b0;
    rd_ready = 1'b1;
    if (got < stop_at) chk("drain_timeout", 64'(got), 64'(stop_at));
    cycles = cyc;
  endtask

  task automatic post_drain(input string tag);
    chk({tag, "_valid_clr"}, 64'(do_valid), 64'(0));
    chk({tag, "_busy_clr"}, 64'(busy), 64'(0));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(do_valid), 64'(0));
    chk("rst_last", 64'(do_last), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_ovf", 64'(overflow), 64'(0));
    chk("rst_seq", 64'(seq_err), 64'(0));
    chk("rst_data", 64'({do_re, do_im}), 64'(0));
    rst = 1'b0;
    tick;

    // points=0 is ignored
    points = '0;
    di_en = 1'b1;
    tick;
    di_en = 1'b0;
    chk("p0_busy", 64'(busy), 64'(0));
    chk("p0_seq", 64'(seq_err), 64'(0));

    // 12 points, free-running consumer
    collect(12, 11);
    chk("p12_busy", 64'(busy), 64'(1));
    drain(12, 1'b0, -1, 12, fv, cy);
    chk("p12_first", 64'(fv), 64'(2));
    chk("p12_cycles", 64'(cy), 64'(14));
    post_drain("p12");
    chk("p12_seq", 64'(seq_err), 64'(0));
    chk("p12_ovf", 64'(overflow), 64'(0));

    // 60 points, random backpressure
    collect(60, 59);
    drain(60, 1'b1, -1, 60, fv, cy);
    post_drain("p60");

    // 1200 points, back-to-back frames
    collect(1200, 1199);
    drain(1200, 1'b0, -1, 1200, fv, cy);
    collect(1200, 1199);
    drain(1200, 1'b1, -1, 1200, fv, cy);
    post_drain("p1200");
    chk("p1200_ovf", 64'(overflow), 64'(0));
    chk("p1200_seq", 64'(seq_err), 64'(0));

    // sample arriving during drain is dropped
    collect(24, 23);
    drain(24, 1'b0, 5, 24, fv, cy);
    post_drain("p24");
    chk("ovf_set", 64'(overflow), 64'(1));
    tick;
    tick;
    chk("ovf_sticky", 64'(overflow), 64'(1));
    do_reset;
    chk("ovf_rst", 64'(overflow), 64'(0));

    // early finish
    collect(12, 10);
    chk("seq_set", 64'(seq_err), 64'(1));
    chk("seq_busy", 64'(busy), 64'(1));
    drain(12, 1'b1, -1, 12, fv, cy);
    post_drain("seq");
    chk("seq_sticky", 64'(seq_err), 64'(1));

    // reset in the middle of a drain
    do_reset;
    collect(36, 35);
    drain(36, 1'b0, -1, 5, fv, cy);
    rst = 1'b1;
    #1;
    chk("mid_valid", 64'(do_valid), 64'(0));
    chk("mid_busy", 64'(busy), 64'(0));
    chk("mid_last", 64'(do_last), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    collect(36, 35);
    drain(36, 1'b1, -1, 36, fv, cy);
    post_drain("p36");
    chk("p36_seq", 64'(seq_err), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
